// File: rtl/pbox_inv_stream.sv
// pbox_inv_stream: buffered inverse DES P-permutation, valid/ready on both ports.
// Optional forward-P self-check is built when PBOX_INV_CHECK_EN is defined.
module pbox_inv_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic             check_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

`ifdef PBOX_INV_CHECK_EN
    localparam int W = 64;
`else
    localparam int W = 32;
`endif

    // DES P table, 1-based, MSB-first (bit 31 is DES bit 1)
    localparam int unsigned PTAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [31:0] p_inv(input logic [31:0] x);
        logic [31:0] r;
        logic [4:0]  src;
        logic [4:0]  dst;
        r = '0;
        for (int i = 1; i <= 32; i++) begin
            src = 5'(32 - i);
            dst = 5'(32 - int'(PTAB[5'(i - 1)]));
            r[dst] = x[src];
        end
        return r;
    endfunction

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          accept;
    logic          pop;
    logic [W-1:0]  entry;
    logic [W-1:0]  head;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[31:0] : 32'h0;

`ifdef PBOX_INV_CHECK_EN
    assign entry = {in_data, p_inv(in_data)};
`else
    assign entry = p_inv(in_data);
`endif

    // Storage is not reset; out_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (accept && !flush)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                accept && !pop: count <= count + 1'b1;
                pop && !accept: count <= count - 1'b1;
                default:        count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            word_cnt <= '0;
        else if (accept && !flush)
            word_cnt <= word_cnt + 1'b1;
    end

`ifdef PBOX_INV_CHECK_EN
    function automatic logic [31:0] p_fwd(input logic [31:0] x);
        logic [31:0] r;
        logic [4:0]  src;
        logic [4:0]  dst;
        r = '0;
        for (int i = 1; i <= 32; i++) begin
            dst = 5'(32 - i);
            src = 5'(32 - int'(PTAB[5'(i - 1)]));
            r[dst] = x[src];
        end
        return r;
    endfunction

    logic [31:0] fwd_chk;
    assign fwd_chk = p_fwd(head[31:0]);

    // Sticky until reset; flush leaves it alone
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            check_err <= 1'b0;
        else if (pop && (fwd_chk != head[63:32]))
            check_err <= 1'b1;
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_pbox_inv_stream.sv
// tb_pbox_inv_stream: randomized self-checking bench for pbox_inv_stream.
// Reference model is a queue of raw input words plus DES-numbered P lookups.
module tb_pbox_inv_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             tb_clk = 1'b0;
    logic             n_rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] word_cnt;
    logic             check_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq [$];
    int unsigned model_cnt;

    int ptab [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    pbox_inv_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt),
        .check_err (check_err)
    );

    always #5 tb_clk = ~tb_clk;

    // DES bit k (1..32) lives at vector index 32-k
    function automatic logic [31:0] pbox_ref(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 1; i <= 32; i++)
            r[32 - i] = x[32 - ptab[i - 1]];
        return r;
    endfunction

    function automatic logic [31:0] inv_ref(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int j = 1; j <= 32; j++)
            for (int i = 1; i <= 32; i++)
                if (ptab[i - 1] == j)
                    r[32 - j] = x[32 - i];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic r, input logic f,
                         output logic acc, output logic pop);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc = v && in_ready;
        pop = out_valid && r;
        if (f) begin
            mq.delete();
        end else begin
            if (pop && mq.size() > 0)
                void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                model_cnt++;
            end
        end
        @(posedge tb_clk);
        @(negedge tb_clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        mq.delete();
        model_cnt = 0;
        @(negedge tb_clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (word_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_word_cnt got %0d want 0", word_cnt);
        end
        n_cmp++;
        if (out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_out_data got %h want 0", out_data);
        end
        @(negedge tb_clk);
        n_rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] vin  [5];
        logic [31:0] vexp [5];
        logic acc, pop;
        vin[0] = 32'h0080_0000; vexp[0] = 32'h8000_0000;
        vin[1] = 32'hFF7F_FFFF; vexp[1] = 32'h7FFF_FFFF;
        vin[2] = 32'h0000_0000; vexp[2] = 32'h0000_0000;
        vin[3] = 32'hFFFF_FFFF; vexp[3] = 32'hFFFF_FFFF;
        vin[4] = $urandom;      vexp[4] = inv_ref(vin[4]);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, vin[k], 1'b1, 1'b0, acc, pop);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== vexp[k]) begin
                n_err++;
                $display("FAIL basic_%0d got v=%b %h want v=1 %h",
                         k, out_valid, out_data, vexp[k]);
            end
            if (k == 0) begin
                n_cmp++;
                if (word_cnt !== 16'd1) begin
                    n_err++;
                    $display("FAIL basic_word_cnt got %0d want 1", word_cnt);
                end
            end
            drive(1'b0, 32'h0, 1'b1, 1'b0, acc, pop);
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                n_err++;
                $display("FAIL basic_empty_%0d got v=%b %h want v=0 0",
                         k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        logic acc, pop, held;
        int pops;
        pulse_reset();
        for (int k = 0; k < 5; k++)
            w[k] = $urandom;
        for (int k = 0; k < 4; k++)
            drive(1'b1, w[k], 1'b0, 1'b0, acc, pop);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full_in_ready got %b want 0", in_ready);
        end
        drive(1'b1, w[4], 1'b0, 1'b0, acc, pop);
        n_cmp++;
        if (word_cnt !== 16'd4 || out_data !== inv_ref(w[0])) begin
            n_err++;
            $display("FAIL bp_hold got cnt=%0d %h want 4 %h",
                     word_cnt, out_data, inv_ref(w[0]));
        end
        held = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 12 && pops < 5; cyc++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== inv_ref(w[pops])) begin
                n_err++;
                $display("FAIL bp_order_%0d got v=%b %h want v=1 %h",
                         pops, out_valid, out_data, inv_ref(w[pops]));
            end
            drive(held, w[4], 1'b1, 1'b0, acc, pop);
            if (acc) held = 1'b0;
            if (pop) pops++;
        end
        n_cmp++;
        if (pops != 5 || word_cnt !== 16'd5 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done got pops=%0d cnt=%0d v=%b want 5 5 0",
                     pops, word_cnt, out_valid);
        end
    endtask

    task automatic test_concurrent();
        logic acc, pop;
        logic [31:0] d;
        int pops;
        pulse_reset();
        for (int k = 0; k < 2; k++)
            drive(1'b1, $urandom, 1'b0, 1'b0, acc, pop);
        for (int k = 0; k < 10; k++) begin
            d = $urandom;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1
                || out_data !== inv_ref(mq[0])) begin
                n_err++;
                $display("FAIL conc_%0d got v=%b r=%b %h want 1 1 %h",
                         k, out_valid, in_ready, out_data, inv_ref(mq[0]));
            end
            drive(1'b1, d, 1'b1, 1'b0, acc, pop);
        end
        pops = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (out_valid && mq.size() > 0) begin
                n_cmp++;
                if (out_data !== inv_ref(mq[0])) begin
                    n_err++;
                    $display("FAIL conc_drain got %h want %h",
                             out_data, inv_ref(mq[0]));
                end
            end
            drive(1'b0, 32'h0, 1'b1, 1'b0, acc, pop);
            if (pop) pops++;
        end
        n_cmp++;
        if (pops != 2) begin
            n_err++;
            $display("FAIL conc_level got %0d pops want 2", pops);
        end
    endtask

    task automatic test_flush_reset();
        logic acc, pop;
        pulse_reset();
        for (int k = 0; k < 3; k++)
            drive(1'b1, $urandom, 1'b0, 1'b0, acc, pop);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_in_ready got %b want 1", in_ready);
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, acc, pop);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL flush_empty got v=%b %h want 0 0",
                     out_valid, out_data);
        end
        n_cmp++;
        if (word_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL flush_word_cnt got %0d want 3", word_cnt);
        end
        for (int k = 0; k < 2; k++)
            drive(1'b1, $urandom, 1'b0, 1'b0, acc, pop);
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst got v=%b r=%b want 0 1",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (word_cnt !== '0 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL async_rst_cnt got %0d %h want 0 0",
                     word_cnt, out_data);
        end
        mq.delete();
        model_cnt = 0;
        @(negedge tb_clk);
        n_rst = 1'b1;
    endtask

    task automatic test_random();
        logic acc, pop, v, r;
        logic [31:0] d;
        int sent;
        int cyc;
        pulse_reset();
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || mq.size() > 0) && cyc < 8000) begin
            v = (sent < 1000) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            d = $urandom;
            n_cmp++;
            if (out_valid !== (mq.size() != 0)
                || in_ready !== (mq.size() != DEPTH)) begin
                n_err++;
                $display("FAIL rnd_flags got v=%b r=%b level=%0d",
                         out_valid, in_ready, mq.size());
            end
            if (out_valid && r && mq.size() > 0) begin
                n_cmp++;
                if (pbox_ref(out_data) !== mq[0]
                    || out_data !== inv_ref(mq[0])) begin
                    n_err++;
                    $display("FAIL rnd_pop got %h want %h (in %h)",
                             out_data, inv_ref(mq[0]), mq[0]);
                end
            end
            drive(v, d, r, 1'b0, acc, pop);
            if (acc) sent++;
            cyc++;
        end
        n_cmp++;
        if (sent != 1000 || mq.size() != 0) begin
            n_err++;
            $display("FAIL rnd_timeout got sent=%0d left=%0d want 1000 0",
                     sent, mq.size());
        end
        n_cmp++;
        if (word_cnt !== CNT_W'(model_cnt)) begin
            n_err++;
            $display("FAIL rnd_word_cnt got %0d want %0d",
                     word_cnt, model_cnt);
        end
        n_cmp++;
        if (check_err !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_check_err got %b want 0", check_err);
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        model_cnt = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_concurrent();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
